add_sub_seq_32bit: RTL and testbench

Multi-cycle add/subtract sequencer for the RISC-V ALU. It performs WIDTH-bit add and subtract by time-multiplexing one full_adder_16bit instance over successive 16-bit slices, LSB slice first. Each slice's carry is registered and fed into the next slice. Operands enter and results leave through valid/ready handshakes, so the ALU control FSM can stall the block in either direction.

---
 rtl/add_sub_seq_32bit.sv | 157 +++++++++++++++
 tb/tb_add_sub_seq_32bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/add_sub_seq_32bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : add_sub_seq_32bit (with helper full_adder_16bit)
// Purpose  : Multi-cycle add/subtract sequencer. One 16-bit adder is reused
//            over successive slices, LSB slice first. The carry is
//            registered between slices. Operands and results move through
//            valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

// 16-bit ripple adder slice with carry in/out
module full_adder_16bit (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_c_in,
   output logic [15:0] o_sum,
   output logic        o_c_out
);

   // Widen by one bit so the carry out falls out of the addition
   assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'd0, i_c_in};

endmodule

module add_sub_seq_32bit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_c_out,
   output logic             o_overflow,
   output logic             o_zero
);

   localparam int NUM_SLICES = WIDTH / SLICE;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_result;
   logic             r_out_valid;
   logic             r_c_out;
   logic             r_overflow;
   logic             r_zero;

   logic [SLICE-1:0] w_a_sl [NUM_SLICES];
   logic [SLICE-1:0] w_b_sl [NUM_SLICES];
   logic [SLICE-1:0] w_a_cur;
   logic [SLICE-1:0] w_b_cur;
   logic [SLICE-1:0] w_sum;
   logic             w_adder_c;
   logic [WIDTH-1:0] w_res_next;

   // Split the latched operands into slice-sized views for the mux
   for (genvar g = 0; g < NUM_SLICES; g++) begin : g_slices
      assign w_a_sl[g] = r_a[g*SLICE +: SLICE];
      assign w_b_sl[g] = r_b[g*SLICE +: SLICE];
   end

   assign w_a_cur = w_a_sl[r_idx];
   assign w_b_cur = w_b_sl[r_idx];

   full_adder_16bit u_adder (
      .i_a     (w_a_cur),
      .i_b     (w_b_cur),
      .i_c_in  (r_carry),
      .o_sum   (w_sum),
      .o_c_out (w_adder_c)
   );

   // Result with the current slice merged in; the flags on the final
   // slice are computed from this so they see the complete word
   always_comb begin
      w_res_next = r_result;
      w_res_next[int'(r_idx)*SLICE +: SLICE] = w_sum;
   end

   assign o_in_ready  = (r_state == S_IDLE);
   assign o_out_valid = r_out_valid;
   assign o_result    = r_result;
   assign o_c_out     = r_c_out;
   assign o_overflow  = r_overflow;
   assign o_zero      = r_zero;

   // Sequencer: accept, run one slice per cycle, hold result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_c_out     <= 1'b0;
         r_overflow  <= 1'b0;
         r_zero      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_in_valid) begin
                  r_a     <= i_a;
                  // Subtraction is a + ~b + 1; the +1 rides in the carry
                  r_b     <= i_sub ? ~i_b : i_b;
                  r_carry <= i_sub;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_result <= w_res_next;
               r_carry  <= w_adder_c;
               r_idx    <= r_idx + 1'b1;
               if (r_idx == C_LAST_IDX) begin
                  r_c_out     <= w_adder_c;
                  r_overflow  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
                  r_zero      <= (w_res_next == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq_32bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_add_sub_seq_32bit
// Purpose  : Directed self-checking bench for add_sub_seq_32bit
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_seq_32bit;

   logic        clk;
   logic        rst_n;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        i_sub;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_result;
   logic        o_c_out;
   logic        o_overflow;
   logic        o_zero;

   int total = 0;
   int bad   = 0;

   add_sub_seq_32bit #(.WIDTH(32), .SLICE(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_sub       (i_sub),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_result    (o_result),
      .o_c_out     (o_c_out),
      .o_overflow  (o_overflow),
      .o_zero      (o_zero)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One operation: accept, measure latency, check outputs, optionally
   // stall the consumer for 'hold' cycles, then hand off.
   task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er, input logic ec,
                        input logic eo, input logic ez, input int hold,
                        input logic scramble);
      int lat;
      @(negedge clk);
      i_a = a; i_b = b; i_sub = sub; i_in_valid = 1'b1; i_out_ready = 1'b0;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      if (scramble) begin
         i_a = ~a; i_b = 32'h5A5A_5A5A; i_sub = ~sub;
      end
      lat = 0;
      while (!o_out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_result"}, o_result, er);
      check({tag, "_c_out"}, {31'd0, o_c_out}, {31'd0, ec});
      check({tag, "_overflow"}, {31'd0, o_overflow}, {31'd0, eo});
      check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, ez});
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, {31'd0, o_out_valid}, 32'd1);
         check({tag, "_hold_result"}, o_result, er);
         check({tag, "_hold_flags"}, {29'd0, o_c_out, o_overflow, o_zero}, {29'd0, ec, eo, ez});
         check({tag, "_hold_in_ready"}, {31'd0, o_in_ready}, 32'd0);
      end
      @(negedge clk);
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      i_out_ready = 1'b0;
      check({tag, "_handoff_valid"}, {31'd0, o_out_valid}, 32'd0);
      check({tag, "_handoff_in_ready"}, {31'd0, o_in_ready}, 32'd1);
      check({tag, "_kept_result"}, o_result, er);
   endtask

   initial begin
      rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_a = '0; i_b = '0; i_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("in_reset_in_ready", {31'd0, o_in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_in_ready", {31'd0, o_in_ready}, 32'd1);
      check("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
      check("reset_result", o_result, 32'd0);
      check("reset_flags", {29'd0, o_c_out, o_overflow, o_zero}, 32'd0);

      do_op("slice_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      do_op("full_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
      do_op("signed_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
      do_op("sub_5_7",     32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      do_op("sub_7_5",     32'd7,         32'd5,         1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      do_op("sub_min_1",   32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      // Consumer stall for 5 cycles with operands changed during RUN
      do_op("hold_scram",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 5, 1'b1);

      // Reset during the first RUN cycle discards the operation
      @(negedge clk);
      i_a = 32'd9; i_b = 32'd9; i_sub = 1'b0; i_in_valid = 1'b1;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      check("run_entered_in_ready", {31'd0, o_in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_valid", {31'd0, o_out_valid}, 32'd0);
      check("midrun_rst_result", o_result, 32'd0);
      check("midrun_rst_flags", {29'd0, o_c_out, o_overflow, o_zero}, 32'd0);
      check("midrun_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("after_rst_no_valid", {31'd0, o_out_valid}, 32'd0);
         check("after_rst_result", o_result, 32'd0);
      end

      do_op("add_3_4", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
